// File: rtl/mips16_ctrl_pkg.sv
// Shared encodings for the 16-bit MIPS multicycle control path: opcodes,
// alu_op codes (also consumed by alu_control), FSM states and mux selects.
package mips16_ctrl_pkg;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ANDI = 4'b0010;
  localparam logic [3:0] OP_ORI  = 4'b0011;
  localparam logic [3:0] OP_NORI = 4'b0100;
  localparam logic [3:0] OP_BEQ  = 4'b0101;
  localparam logic [3:0] OP_BNE  = 4'b0110;
  localparam logic [3:0] OP_SLTI = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_J    = 4'b1010;

  localparam logic [2:0] ALUOP_ADD  = 3'b000;
  localparam logic [2:0] ALUOP_NOR  = 3'b001;
  localparam logic [2:0] ALUOP_SUB  = 3'b010;
  localparam logic [2:0] ALUOP_AND  = 3'b011;
  localparam logic [2:0] ALUOP_R    = 3'b100;
  localparam logic [2:0] ALUOP_SLT  = 3'b101;
  localparam logic [2:0] ALUOP_ADDI = 3'b110;
  localparam logic [2:0] ALUOP_OR   = 3'b111;

  localparam logic [1:0] ALUSRCB_RT    = 2'b00;
  localparam logic [1:0] ALUSRCB_TWO   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  function automatic logic is_itype(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
           (op == OP_NORI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/mc_aluop_decode.sv
// Maps the latched opcode of an immediate-ALU instruction to its alu_op.
module mc_aluop_decode
  import mips16_ctrl_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int ALUOP_W = 3
) (
  input  logic [OP_W-1:0]    i_opcode,
  output logic [ALUOP_W-1:0] o_alu_op
);

  logic [2:0] w_alu_op;

  always_comb begin
    w_alu_op = ALUOP_ADD;
    case (4'(i_opcode))
      OP_ADDI: w_alu_op = ALUOP_ADDI;
      OP_ANDI: w_alu_op = ALUOP_AND;
      OP_ORI:  w_alu_op = ALUOP_OR;
      OP_NORI: w_alu_op = ALUOP_NOR;
      OP_SLTI: w_alu_op = ALUOP_SLT;
      default: w_alu_op = ALUOP_ADD;
    endcase
  end

  assign o_alu_op = ALUOP_W'(w_alu_op);

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle main-control FSM: sequences fetch/decode/execute/memory/writeback
// and stalls on the memory req/ready handshake.
module multicycle_main_control
  import mips16_ctrl_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int ALUOP_W = 3,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_branch,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_opcode;
  logic [3:0]       w_opcode_in;
  logic [ALUOP_W-1:0] w_imm_alu_op;

  assign w_opcode_in = 4'(opcode);

  // Later states decode the copy captured in DECODE, so IR may change freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_opcode <= 4'b0000;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) r_opcode <= w_opcode_in;
    end
  end

  mc_aluop_decode #(
    .OP_W    (4),
    .ALUOP_W (ALUOP_W)
  ) u_aluop_decode (
    .i_opcode (r_opcode),
    .o_alu_op (w_imm_alu_op)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:    w_next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((w_opcode_in == OP_LW) || (w_opcode_in == OP_SW)) w_next_state = S_MEM_ADDR;
        else if (w_opcode_in == OP_R)                          w_next_state = S_R_EXEC;
        else if (is_itype(w_opcode_in))                        w_next_state = S_I_EXEC;
        else if ((w_opcode_in == OP_BEQ) || (w_opcode_in == OP_BNE)) w_next_state = S_BRANCH;
        else if (w_opcode_in == OP_J)                          w_next_state = S_JUMP;
        else                                                   w_next_state = S_FETCH;
      end
      S_MEM_ADDR: w_next_state = (r_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   w_next_state = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   w_next_state = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   w_next_state = S_R_WB;
      S_I_EXEC:   w_next_state = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: w_next_state = S_FETCH;
      default:    w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_branch  = 1'b0;
    pc_src     = PCSRC_ALU;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUSRCB_RT;
    alu_op     = ALUOP_W'(ALUOP_ADD);
    illegal_op = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUSRCB_TWO;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = ALUSRCB_IMMSH;
        illegal_op = !((w_opcode_in == OP_LW) || (w_opcode_in == OP_SW) ||
                       (w_opcode_in == OP_R) || is_itype(w_opcode_in) ||
                       (w_opcode_in == OP_BEQ) || (w_opcode_in == OP_BNE) ||
                       (w_opcode_in == OP_J));
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUSRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(ALUOP_R);
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUSRCB_IMM;
        alu_op    = w_imm_alu_op;
      end
      S_I_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(ALUOP_SUB);
        pc_src    = PCSRC_ALUOUT;
        pc_branch = (r_opcode == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  assign state_dbg = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: walks each instruction class
// through the FSM and checks state and control outputs cycle by cycle.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       mem_ready;
  logic       zero;
  logic       mem_read, mem_write, iord, ir_write, pc_write, pc_branch;
  logic [1:0] pc_src;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       illegal_op;
  logic [3:0] state_dbg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int start_cyc;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEM_ADDR = 4'd2,
                         ST_MEM_RD = 4'd3, ST_MEM_WB = 4'd4, ST_MEM_WR = 4'd5,
                         ST_R_EXEC = 4'd6, ST_R_WB = 4'd7, ST_I_EXEC = 4'd8,
                         ST_I_WB = 4'd9, ST_BRANCH = 4'd10, ST_JUMP = 4'd11;

  always #5 clk = ~clk;

  multicycle_main_control #(.OP_W(4), .ALUOP_W(3), .STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_branch  (pc_branch),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opcode = 4'b0000; mem_ready = 1'b0; zero = 1'b0;
    tick(); tick();
    chk("rst_state", 8'(state_dbg), 8'(ST_FETCH));
    chk("rst_mem_read", 8'(mem_read), 8'd1);
    chk("rst_reg_write", 8'(reg_write), 8'd0);
    chk("rst_ir_write", 8'(ir_write), 8'd0);
    chk("rst_mem_write", 8'(mem_write), 8'd0);
    reset = 1'b0;
    tick();
    chk("fetch_stall", 8'(state_dbg), 8'(ST_FETCH));

    // addi, with opcode perturbed after DECODE to prove it is latched
    start_cyc = cyc;
    mem_ready = 1'b1; #1;
    chk("fetch_ir_write", 8'(ir_write), 8'd1);
    chk("fetch_pc_write", 8'(pc_write), 8'd1);
    chk("fetch_src_b", 8'(alu_src_b), 8'h1);
    tick(); opcode = 4'b0001; #1;
    chk("addi_decode", 8'(state_dbg), 8'(ST_DECODE));
    chk("decode_src_b", 8'(alu_src_b), 8'h3);
    chk("decode_no_illegal", 8'(illegal_op), 8'd0);
    tick(); opcode = 4'b0010; #1;
    chk("addi_iexec", 8'(state_dbg), 8'(ST_I_EXEC));
    chk("addi_alu_op", 8'(alu_op), 8'h6);
    chk("addi_src_b", 8'(alu_src_b), 8'h2);
    chk("addi_src_a", 8'(alu_src_a), 8'd1);
    tick();
    chk("addi_iwb", 8'(state_dbg), 8'(ST_I_WB));
    chk("addi_reg_write", 8'(reg_write), 8'd1);
    chk("addi_reg_dst", 8'(reg_dst), 8'd0);
    tick();
    chk("addi_back_fetch", 8'(state_dbg), 8'(ST_FETCH));
    chk("addi_latency", 8'(cyc - start_cyc), 8'd4);

    // remaining immediate ops: andi 011, ori 111, nori 001, slti 101
    begin
      logic [3:0] ops [4] = '{4'b0010, 4'b0011, 4'b0100, 4'b0111};
      logic [2:0] exp [4] = '{3'b011, 3'b111, 3'b001, 3'b101};
      for (int i = 0; i < 4; i++) begin
        opcode = ops[i];
        tick(); tick();
        chk("imm_alu_op", 8'(alu_op), 8'(exp[i]));
        tick(); tick();
      end
    end

    // R-type
    opcode = 4'b0000;
    tick(); tick();
    chk("r_exec", 8'(state_dbg), 8'(ST_R_EXEC));
    chk("r_alu_op", 8'(alu_op), 8'h4);
    chk("r_src_b", 8'(alu_src_b), 8'h0);
    tick();
    chk("r_wb", 8'(state_dbg), 8'(ST_R_WB));
    chk("r_reg_dst", 8'(reg_dst), 8'd1);
    chk("r_reg_write", 8'(reg_write), 8'd1);
    tick();
    chk("r_back_fetch", 8'(state_dbg), 8'(ST_FETCH));

    // lw with three stall cycles in MEM_RD
    start_cyc = cyc;
    opcode = 4'b1000;
    tick(); tick();
    chk("lw_mem_addr", 8'(state_dbg), 8'(ST_MEM_ADDR));
    chk("lw_addr_src_b", 8'(alu_src_b), 8'h2);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_stall_state", 8'(state_dbg), 8'(ST_MEM_RD));
      chk("lw_stall_rd_iord", 8'({mem_read, iord, mem_write}), 8'b110);
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("lw_last_rd", 8'({mem_read, iord}), 8'b11);
    tick();
    chk("lw_mem_wb", 8'(state_dbg), 8'(ST_MEM_WB));
    chk("lw_wb_ctrl", 8'({mem_to_reg, reg_write, reg_dst}), 8'b110);
    tick();
    chk("lw_latency", 8'(cyc - start_cyc), 8'd8);
    chk("lw_back_fetch", 8'(state_dbg), 8'(ST_FETCH));

    // reset held two cycles while a read is in flight
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    chk("rst_pre_mem_rd", 8'(state_dbg), 8'(ST_MEM_RD));
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0; #1;
    chk("rst_mid_state", 8'(state_dbg), 8'(ST_FETCH));
    chk("rst_mid_mem_read", 8'(mem_read), 8'd1);
    chk("rst_mid_ctrl", 8'({reg_write, mem_write, iord}), 8'b000);

    // sw with one stall
    mem_ready = 1'b1; opcode = 4'b1001;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    chk("sw_mem_wr", 8'(state_dbg), 8'(ST_MEM_WR));
    chk("sw_ctrl", 8'({mem_write, mem_read, iord}), 8'b101);
    tick();
    chk("sw_stall", 8'(state_dbg), 8'(ST_MEM_WR));
    mem_ready = 1'b1;
    tick();
    chk("sw_back_fetch", 8'(state_dbg), 8'(ST_FETCH));

    // beq then bne
    opcode = 4'b0101; zero = 1'b1;
    tick(); tick();
    chk("beq_state", 8'(state_dbg), 8'(ST_BRANCH));
    chk("beq_taken", 8'(pc_branch), 8'd1);
    chk("beq_pc_src", 8'(pc_src), 8'h1);
    chk("beq_alu_op", 8'(alu_op), 8'h2);
    zero = 1'b0; #1;
    chk("beq_not_taken", 8'(pc_branch), 8'd0);
    tick();
    opcode = 4'b0110; zero = 1'b1;
    tick(); tick();
    chk("bne_zero1", 8'(pc_branch), 8'd0);
    zero = 1'b0; #1;
    chk("bne_zero0", 8'(pc_branch), 8'd1);
    tick();

    // jump: three cycles
    start_cyc = cyc;
    opcode = 4'b1010;
    tick(); tick();
    chk("j_state", 8'(state_dbg), 8'(ST_JUMP));
    chk("j_ctrl", 8'({pc_write, pc_src}), 8'b110);
    tick();
    chk("j_latency", 8'(cyc - start_cyc), 8'd3);

    // illegal opcode
    opcode = 4'b1100;
    tick();
    chk("ill_decode", 8'(state_dbg), 8'(ST_DECODE));
    chk("ill_pulse", 8'(illegal_op), 8'd1);
    chk("ill_no_writes", 8'({reg_write, mem_write}), 8'b00);
    tick();
    chk("ill_back_fetch", 8'(state_dbg), 8'(ST_FETCH));
    chk("ill_pulse_end", 8'(illegal_op), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
